// File: rtl/tour_cmd.sv
// Replays the solved knight's tour as vertical/horizontal drive commands, and passes
// UART commands straight through whenever no tour is playing.
module tour_cmd #(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    localparam int unsigned IDX_W    = 5;
    localparam int unsigned SQ_W     = 4;
    localparam logic [3:0]  OP_VERT  = 4'h2;
    localparam logic [3:0]  OP_HORZ  = 4'h3;
    localparam logic [7:0]  HDG_N    = 8'h00;
    localparam logic [7:0]  HDG_W    = 8'h3F;
    localparam logic [7:0]  HDG_S    = 8'h7F;
    localparam logic [7:0]  HDG_E    = 8'hBF;
    localparam logic [7:0]  RESP_BSY = 8'h5A;
    localparam logic [7:0]  RESP_IDL = 8'hA5;

    typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   mv_indx_q;
    logic [7:0]         resp_q;

    logic [2:0]         lsb;
    logic               any_bit;
    logic               v_pos;
    logic               h_pos;
    logic [SQ_W-1:0]    v_sq;
    logic [SQ_W-1:0]    h_sq;
    logic [15:0]        cmd_vert;
    logic [15:0]        cmd_horz;

    // Tour sequencing; resp tracks whether the next state is a tour state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            resp_q    <= RESP_IDL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx_q <= '0;
                        state_q   <= VERT;
                        resp_q    <= RESP_BSY;
                    end
                end
                VERT:   if (clr_cmd_rdy) state_q <= HOLD_V;
                HOLD_V: if (send_resp)   state_q <= HORZ;
                HORZ:   if (clr_cmd_rdy) state_q <= HOLD_H;
                HOLD_H: begin
                    if (send_resp) begin
                        if (mv_indx_q == IDX_W'(NUM_MOVES - 1)) begin
                            state_q <= IDLE;
                            resp_q  <= RESP_IDL;
                        end else begin
                            mv_indx_q <= mv_indx_q + IDX_W'(1);
                            state_q   <= VERT;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= RESP_IDL;
                end
            endcase
        end
    end

    // Lowest set bit of move selects the knight offset.
    always_comb begin
        lsb     = '0;
        any_bit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) begin
                lsb     = 3'(i);
                any_bit = 1'b1;
            end
        end
    end

    always_comb begin
        v_pos = 1'b1;
        h_pos = 1'b1;
        v_sq  = '0;
        h_sq  = '0;
        case (lsb)
            3'd0: begin v_pos = 1'b1; v_sq = 4'd1; h_pos = 1'b1; h_sq = 4'd2; end
            3'd1: begin v_pos = 1'b1; v_sq = 4'd2; h_pos = 1'b1; h_sq = 4'd1; end
            3'd2: begin v_pos = 1'b1; v_sq = 4'd2; h_pos = 1'b0; h_sq = 4'd1; end
            3'd3: begin v_pos = 1'b1; v_sq = 4'd1; h_pos = 1'b0; h_sq = 4'd2; end
            3'd4: begin v_pos = 1'b0; v_sq = 4'd1; h_pos = 1'b0; h_sq = 4'd2; end
            3'd5: begin v_pos = 1'b0; v_sq = 4'd2; h_pos = 1'b0; h_sq = 4'd1; end
            3'd6: begin v_pos = 1'b0; v_sq = 4'd2; h_pos = 1'b1; h_sq = 4'd1; end
            3'd7: begin v_pos = 1'b0; v_sq = 4'd1; h_pos = 1'b1; h_sq = 4'd2; end
        endcase
        if (any_bit) begin
            cmd_vert = {OP_VERT, (v_pos ? HDG_N : HDG_S), v_sq};
            cmd_horz = {OP_HORZ, (h_pos ? HDG_E : HDG_W), h_sq};
        end else begin
            cmd_vert = {OP_VERT, HDG_N, 4'd0};
            cmd_horz = {OP_HORZ, HDG_N, 4'd0};
        end
    end

    // Output mux: UART pass-through when idle, tour legs otherwise.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        case (state_q)
            VERT:    begin cmd = cmd_vert; cmd_rdy = 1'b1; end
            HOLD_V:  begin cmd = cmd_vert; cmd_rdy = 1'b0; end
            HORZ:    begin cmd = cmd_horz; cmd_rdy = 1'b1; end
            HOLD_H:  begin cmd = cmd_horz; cmd_rdy = 1'b0; end
            default: ;
        endcase
    end

    assign mv_indx = mv_indx_q;
    assign resp    = resp_q;

endmodule
